// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, fetches from combinational imem into a small FIFO, hands {pc, instr} to decode.
// Define FETCH_CTRL_PERF_EN to add saturating fetch/stall/flush counters.
module fetch_ctrl #(
    parameter logic [63:0] PC_RESET   = 64'h0,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt_req,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instr,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
`endif
    output logic        halted
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
    state_t        state, state_nx;
    logic [63:0]   pc;
    logic [63:0]   fifo_pc [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count, count_nx;
    logic          redir, push, pop;
    assign imem_addr = pc;
    // A redirect in IDLE is ignored; elsewhere it flushes and blocks both push and pop.
    always_comb begin
        redir    = redirect_valid && state != IDLE;
        id_valid = count != '0 && !redir;
        pop      = id_valid && id_ready;
        push     = state == FETCH && !halt_req && !redir && (count != FULL || pop);
        count_nx = redir ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
        state_nx = redir ? state : (halt_req ? HALT : FETCH);
        id_pc    = id_valid ? fifo_pc[head] : '0;
        id_instr = id_valid ? fifo_instr[head] : NOP_INSTR;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pc     <= PC_RESET;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            halted <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            halted <= state_nx == HALT && count_nx == '0;
            if (redir) begin
                pc   <= {redirect_pc[63:2], 2'b00};
                head <= '0;
                tail <= '0;
            end else begin
                if (push) begin
                    fifo_pc[tail]    <= pc;
                    fifo_instr[tail] <= imem_rdata;
                    tail             <= tail + 1'b1;
                    pc               <= pc + 64'd4;
                end
                if (pop) head <= head + 1'b1;
            end
        end
    end
`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else begin
            if (push && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
            if (id_valid && !id_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
            if (redir && perf_flush != '1) perf_flush <= perf_flush + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors for fetch_ctrl with hand-traced expected PCs per cycle.
module tb_fetch_ctrl;
    localparam logic [63:0] PC_RST = 64'h1000;
    localparam logic [31:0] NOP    = 32'h00000013;
    logic        clk, reset;
    logic [63:0] imem_addr, redirect_pc, id_pc;
    logic [31:0] imem_rdata, id_instr;
    logic        redirect_valid, halt_req, id_ready, id_valid, halted;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif
    int checks = 0;
    int errors = 0;
    fetch_ctrl #(.PC_RESET(PC_RST), .FIFO_DEPTH(2), .NOP_INSTR(NOP)) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt_req(halt_req),
        .id_ready(id_ready),
        .id_valid(id_valid),
        .id_pc(id_pc),
        .id_instr(id_instr),
`ifdef FETCH_CTRL_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall),
        .perf_flush(perf_flush),
`endif
        .halted(halted)
    );
    function automatic logic [31:0] mem(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction
    assign imem_rdata = mem(imem_addr);
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic head_is(input string tag, input logic v, input logic [63:0] p);
        chk({tag, "_valid"}, 64'(id_valid), 64'(v));
        chk({tag, "_pc"}, id_pc, v ? p : 64'h0);
        chk({tag, "_instr"}, 64'(id_instr), 64'(v ? mem(p) : NOP));
    endtask
    task automatic step(input logic rv, input logic [63:0] rpc, input logic h, input logic rdy);
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = h;
        id_ready       = rdy;
        #1;
    endtask
    task automatic release_reset(input logic rdy);
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt_req = 1'b0;
        id_ready = rdy;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask
    task automatic reset_values(input string tag);
        head_is(tag, 1'b0, 64'h0);
        chk({tag, "_halted"}, 64'(halted), 64'h0);
        chk({tag, "_addr"}, imem_addr, PC_RST);
`ifdef FETCH_CTRL_PERF_EN
        chk({tag, "_pf"}, 64'(perf_fetched), 64'h0);
        chk({tag, "_ps"}, 64'(perf_stall), 64'h0);
        chk({tag, "_pl"}, 64'(perf_flush), 64'h0);
`endif
    endtask
    initial begin
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt_req = 1'b0;
        id_ready = 1'b1;
        #12;
        reset_values("rst");
        // streaming with decode always ready
        release_reset(1'b1);
        head_is("c0", 1'b0, 64'h0);
        step(0, 0, 0, 1);
        head_is("c1", 1'b0, 64'h0);
        chk("c1_addr", imem_addr, 64'h1000);
        step(0, 0, 0, 1);
        head_is("c2", 1'b1, 64'h1000);
        step(0, 0, 0, 1);
        head_is("c3", 1'b1, 64'h1004);
        step(0, 0, 0, 1);
        head_is("c4", 1'b1, 64'h1008);
        chk("c4_addr", imem_addr, 64'h100C);
        // decode stall from reset: two pushes then pc holds
        release_reset(1'b0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        head_is("s2", 1'b1, 64'h1000);
        step(0, 0, 0, 0);
        chk("s3_addr", imem_addr, 64'h1008);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        head_is("s5", 1'b1, 64'h1000);
        chk("s5_addr", imem_addr, 64'h1008);
        step(0, 0, 0, 1);
        head_is("s6", 1'b1, 64'h1000);
        step(0, 0, 0, 1);
        head_is("s7", 1'b1, 64'h1004);
        step(0, 0, 0, 0);
        head_is("s8", 1'b1, 64'h1008);
        // redirect with FIFO full to an unaligned target
        step(1, 64'h2002, 0, 1);
        head_is("r0", 1'b0, 64'h0);
        chk("r0_addr", imem_addr, 64'h1010);
        step(0, 0, 0, 1);
        head_is("r1", 1'b0, 64'h0);
        chk("r1_addr", imem_addr, 64'h2000);
        step(0, 0, 0, 1);
        head_is("r2", 1'b1, 64'h2000);
        // halt with two entries buffered
        step(0, 0, 0, 0);
        head_is("h0", 1'b1, 64'h2004);
        step(0, 0, 1, 1);
        head_is("h1", 1'b1, 64'h2004);
        chk("h1_halted", 64'(halted), 64'h0);
        step(0, 0, 1, 1);
        head_is("h2", 1'b1, 64'h2008);
        chk("h2_halted", 64'(halted), 64'h0);
        chk("h2_addr", imem_addr, 64'h200C);
        step(0, 0, 0, 1);
        head_is("h3", 1'b0, 64'h0);
        chk("h3_halted", 64'(halted), 64'h1);
        chk("h3_addr", imem_addr, 64'h200C);
        step(0, 0, 0, 1);
        chk("h4_halted", 64'(halted), 64'h0);
        step(0, 0, 0, 1);
        head_is("h5", 1'b1, 64'h200C);
        // wrap at the top of the address space
        step(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
        head_is("w0", 1'b0, 64'h0);
        step(0, 0, 0, 1);
        chk("w1_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 1);
        head_is("w2", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("w2_addr", imem_addr, 64'h0);
        step(0, 0, 0, 0);
        head_is("w3", 1'b1, 64'h0);
        // fill, halt, then async reset mid-cycle
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        head_is("a0", 1'b1, 64'h0);
        chk("a0_halted", 64'(halted), 64'h0);
`ifdef FETCH_CTRL_PERF_EN
        chk("a0_pl", 64'(perf_flush), 64'h2);
`endif
        #2;
        reset = 1'b0;
        #1;
        reset_values("arst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
